// File: rtl/sos_render_pkg.sv
// Shared constants, glyph bitmaps and FSM state type for the SOS board renderer.
package sos_render_pkg;

   localparam logic [2:0] CODE_EMPTY   = 3'b000;
   localparam logic [2:0] CODE_S       = 3'b001;
   localparam logic [2:0] CODE_O       = 3'b010;
   localparam logic [2:0] CODE_INVALID = 3'b111;

   localparam logic [2:0] COL_BG     = 3'b000;
   localparam logic [2:0] COL_S      = 3'b100;
   localparam logic [2:0] COL_O      = 3'b001;
   localparam logic [2:0] COL_HILITE = 3'b010;

   localparam int GLYPH_W = 8;

   // Row 0 first; bit 7 of each row is the leftmost pixel.
   localparam logic [0:7][7:0] GLYPH_S = {8'h3C, 8'h42, 8'h40, 8'h3C,
                                          8'h02, 8'h42, 8'h3C, 8'h00};
   localparam logic [0:7][7:0] GLYPH_O = {8'h3C, 8'h42, 8'h42, 8'h42,
                                          8'h42, 8'h42, 8'h3C, 8'h00};

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAW} state_e;

   // Board column / row of a row-major cell index.
   function automatic int cell_col(input logic [3:0] k);
      return int'(k) % 3;
   endfunction

   function automatic int cell_row(input logic [3:0] k);
      return int'(k) / 3;
   endfunction

endpackage

// File: rtl/sos_glyph_rom.sv
// Combinational 8x8 glyph lookup: returns the pixel bit of a cell code.
module sos_glyph_rom
   import sos_render_pkg::*;
(
   input  logic [2:0] code_i,
   input  logic [2:0] yc_i,
   input  logic [2:0] xc_i,
   output logic       pix_o
);

   logic [2:0] bit_idx;
   assign bit_idx = 3'(GLYPH_W - 1) - xc_i;

   // Only S and O have ink; every other code paints background (erase).
   always_comb begin
      pix_o = 1'b0;
      case (code_i)
         CODE_S:  pix_o = GLYPH_S[yc_i][bit_idx];
         CODE_O:  pix_o = GLYPH_O[yc_i][bit_idx];
         default: pix_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/sos_board_renderer.sv
// SOS board renderer: repaints changed cells as 8x8 glyphs on the VGA plot port.
// Optional win highlighting is built when SOS_RENDER_HIGHLIGHT_EN is defined.
module sos_board_renderer
   import sos_render_pkg::*;
#(
   parameter int X0    = 40,
   parameter int Y0    = 20,
   parameter int PITCH = 28
) (
   input  logic        CLOCK_50,
   input  logic        Resetn,
   input  logic [26:0] cell_codes,
`ifdef SOS_RENDER_HIGHLIGHT_EN
   input  logic [8:0]  win_mask,
`endif
   input  logic        redraw,
   output logic        busy,
   output logic        done,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot
);

   state_e     state_q;
   logic [3:0] k_q;
   logic [2:0] xc_q, yc_q;
   logic [2:0] cur_code_q;
   logic [2:0] shadow_q [9];
   logic       force_pend_q, force_pass_q;
   logic       busy_q, done_q, plot_q;
   logic [7:0] x_q;
   logic [6:0] y_q;
   logic [2:0] colour_q;
`ifdef SOS_RENDER_HIGHLIGHT_EN
   logic [8:0] shadow_hl_q;
   logic       cur_hl_q;
   logic       src_hl;
`endif

   logic [2:0] cells [9];
   logic [8:0] cell_diff;
   logic [2:0] src_code, nxc, nyc, fg, colour_d;
   logic [7:0] x_d;
   logic [6:0] y_d;
   logic       pix;

   // Unpack the cell codes and flag every cell whose on-screen copy is stale.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         cells[i]     = cell_codes[3*i +: 3];
`ifdef SOS_RENDER_HIGHLIGHT_EN
         cell_diff[i] = (cells[i] != shadow_q[i]) || (win_mask[i] != shadow_hl_q[i]);
`else
         cell_diff[i] = (cells[i] != shadow_q[i]);
`endif
      end
   end

   // Select the pixel about to be registered: pixel (0,0) of the live code when
   // leaving SCAN, otherwise the raster successor of the pixel on the port.
   always_comb begin
      if (state_q == ST_SCAN) begin
         src_code = cells[k_q];
         nxc      = 3'd0;
         nyc      = 3'd0;
      end else begin
         src_code = cur_code_q;
         nxc      = xc_q + 3'd1;
         nyc      = (xc_q == 3'd7) ? yc_q + 3'd1 : yc_q;
      end
`ifdef SOS_RENDER_HIGHLIGHT_EN
      src_hl = (state_q == ST_SCAN) ? win_mask[k_q] : cur_hl_q;
`endif
   end

   sos_glyph_rom u_rom (
      .code_i (src_code),
      .yc_i   (nyc),
      .xc_i   (nxc),
      .pix_o  (pix)
   );

   // Screen coordinates and colour of the selected pixel.
   always_comb begin
      x_d = 8'(X0 + cell_col(k_q) * PITCH + int'(nxc));
      y_d = 7'(Y0 + cell_row(k_q) * PITCH + int'(nyc));
      fg  = (src_code == CODE_S) ? COL_S : COL_O;
`ifdef SOS_RENDER_HIGHLIGHT_EN
      if (src_hl) fg = COL_HILITE;
`endif
      colour_d = pix ? fg : COL_BG;
   end

   // Main FSM: IDLE watches for stale cells, SCAN walks cells, DRAW emits 64 pixels.
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q      <= ST_IDLE;
         k_q          <= 4'd0;
         xc_q         <= 3'd0;
         yc_q         <= 3'd0;
         cur_code_q   <= CODE_EMPTY;
         force_pend_q <= 1'b0;
         force_pass_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         plot_q       <= 1'b0;
         x_q          <= 8'd0;
         y_q          <= 7'd0;
         colour_q     <= COL_BG;
         for (int i = 0; i < 9; i++) shadow_q[i] <= CODE_INVALID;
`ifdef SOS_RENDER_HIGHLIGHT_EN
         shadow_hl_q  <= 9'd0;
         cur_hl_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (redraw) force_pend_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if ((|cell_diff) || force_pend_q) begin
                  state_q      <= ST_SCAN;
                  k_q          <= 4'd0;
                  busy_q       <= 1'b1;
                  force_pass_q <= force_pend_q;
                  force_pend_q <= redraw;
               end
            end
            ST_SCAN: begin
               if (cell_diff[k_q] || force_pass_q) begin
                  state_q    <= ST_DRAW;
                  cur_code_q <= cells[k_q];
`ifdef SOS_RENDER_HIGHLIGHT_EN
                  cur_hl_q   <= win_mask[k_q];
`endif
                  xc_q       <= 3'd0;
                  yc_q       <= 3'd0;
                  plot_q     <= 1'b1;
                  x_q        <= x_d;
                  y_q        <= y_d;
                  colour_q   <= colour_d;
               end else if (k_q != 4'd8) begin
                  k_q <= k_q + 4'd1;
               end else begin
                  state_q      <= ST_IDLE;
                  k_q          <= 4'd0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  force_pass_q <= 1'b0;
               end
            end
            ST_DRAW: begin
               if (xc_q == 3'd7 && yc_q == 3'd7) begin
                  plot_q        <= 1'b0;
                  shadow_q[k_q] <= cur_code_q;
`ifdef SOS_RENDER_HIGHLIGHT_EN
                  shadow_hl_q[k_q] <= cur_hl_q;
`endif
                  if (k_q != 4'd8) begin
                     state_q <= ST_SCAN;
                     k_q     <= k_q + 4'd1;
                  end else begin
                     state_q      <= ST_IDLE;
                     k_q          <= 4'd0;
                     busy_q       <= 1'b0;
                     done_q       <= 1'b1;
                     force_pass_q <= 1'b0;
                  end
               end else begin
                  xc_q     <= nxc;
                  yc_q     <= nyc;
                  x_q      <= x_d;
                  y_q      <= y_d;
                  colour_q <= colour_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign vga_plot   = plot_q;
   assign vga_x      = x_q;
   assign vga_y      = y_q;
   assign vga_colour = colour_q;

endmodule

// File: doc/sos_board_renderer.md
# sos_board_renderer

Pixel-write initiator for the VGA adapter's plot port. Holds a shadow copy of the nine SOS board cells, detects which cells differ from what is on screen, and repaints only those cells as 8x8 glyphs through `vga_x`, `vga_y`, `vga_colour` and `vga_plot`. It sits between the game-state registers (the 3-bit cell codes) and `vga_adapter`, replacing key-driven plotting.

## Interface
- `X0`, default 40: x pixel of the column-0 cell origin.
- `Y0`, default 20: y pixel of the row-0 cell origin.
- `PITCH`, default 28: cell-to-cell spacing in pixels. Requires X0+2*PITCH+7 ≤ 159 and Y0+2*PITCH+7 ≤ 119.
- `CLOCK_50`, input, 1 bit: clock.
- `Resetn`, input, 1 bit: reset, synchronous, active-low. Clock is CLOCK_50.
- `cell_codes`, input, 27 bits: cell k is in bits [3k+2:3k]. k=0 is top-left, numbered row-major. 000 = empty, 001 = S, 010 = O.
- `win_mask`, input, 9 bits: bit k highlights cell k. Present only with SOS_RENDER_HIGHLIGHT_EN.
- `redraw`, input, 1 bit: single-cycle pulse that forces a full repaint.
- `busy`, output, 1 bit: high while a repaint pass is in progress.
- `done`, output, 1 bit: 1-cycle pulse at the end of each pass.
- `vga_x`, output, 8 bits: pixel x.
- `vga_y`, output, 7 bits: pixel y.
- `vga_colour`, output, 3 bits: RGB colour.
- `vga_plot`, output, 1 bit: write strobe.

## Operation
- **State machine:** IDLE, SCAN, DRAW.
- **Shadow registers:** `shadow[k]` (3 bits each) holds the code last drawn in cell k. Reset loads 3'b111 into every entry, so the first pass after reset repaints all nine cells.
- **IDLE:**
  - Every cycle, compares `cell_codes` against `shadow`.
  - Goes to SCAN with k=0 if any cell differs or a force flag is set.
- **redraw:**
  - Sets `force_pend` in any state.
  - On the IDLE→SCAN transition, `force_pend` moves into `force_pass` and `force_pend` clears.
  - A redraw pulse that arrives while busy therefore applies to the next pass.
- **SCAN (1 cycle per cell k):**
  - If `cell_codes[k] != shadow[k]` or `force_pass`, snapshot the code into `cur_code` and go to DRAW with xc=yc=0.
  - Otherwise, if k<8, set k←k+1.
  - Otherwise (k=8), go to IDLE, pulse `done`, and clear `force_pass`.
- **DRAW (64 cycles):**
  - Raster order, xc inner and yc outer, both 3 bits.
  - `vga_x = X0 + (k%3)*PITCH + xc`; `vga_y = Y0 + (k/3)*PITCH + yc`.
  - Arithmetic is computed at 8 bits; `vga_y` is truncated to 7 bits.
  - `vga_colour` is the foreground colour if the glyph bit is set, otherwise 3'b000.
  - Foreground colours: S = 3'b100, O = 3'b001.
  - Codes 000 and 011–111 draw all-background. This is how a cell is erased.
  - After pixel (7,7):
    - `shadow[k] ← cur_code`.
    - If k<8, set k←k+1 and return to SCAN.
    - If k=8, go to IDLE, pulse `done`, and clear `force_pass`.
- **Glyph rows** (yc = 0..7, bit 7 is xc=0):
  - S: 3C 42 40 3C 02 42 3C 00.
  - O: 3C 42 42 42 42 42 3C 00.
- **Input changes mid-pass:**
  - A change during DRAW does not affect the cell being drawn, because the code is taken from `cur_code`.
  - The change is picked up as a mismatch on the next pass.
  - Changes to cells not yet scanned are picked up in the current pass.
- **Reset mid-pass:**
  - At the next edge, `vga_plot` is 0 and state is IDLE.
  - `shadow` is invalidated, so a full repaint follows reset release.

## Timing
- **Reset values:** `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0, `busy`=0, `done`=0, `force_pend`=0, `force_pass`=0, `shadow`=all 3'b111, k=0.
- **Registered outputs:** all outputs are registered. `vga_x`, `vga_y` and `vga_colour` are valid in every cycle in which `vga_plot`=1.
- **Plot burst:** `vga_plot` is high for exactly 64 consecutive cycles per drawn cell and low at all other times.
- **busy:** equals state≠IDLE, registered.
- **Latency:** if `cell_codes` changes at edge N while in IDLE with cells 0..k-1 unchanged:
  - SCAN k=0 at N+1.
  - First plot of cell k at N+k+2.
- **Full pass duration:** 9×65 = 585 busy cycles. `done` is asserted on the cycle `busy` falls.
- **Idle pass:** a pass with no mismatches and no force flag never starts.
- **Back-to-back passes:** if a mismatch is pending when a pass ends, the next pass starts 1 cycle later, with at least 1 cycle of IDLE in between.

## Configuration
- **Macro:** `SOS_RENDER_HIGHLIGHT_EN`.
- **When defined:**
  - The `win_mask` port exists.
  - Each shadow entry gains a highlight bit.
  - A cell mismatches if its code or its mask bit differs.
  - The foreground colour for a masked, non-empty cell is 3'b010.
  - The highlight bit is snapshotted together with the code.
- **When undefined:**
  - No `win_mask` port.
  - The foreground colour depends on the code only.
  - The shadow is 3 bits per cell.

## Structure
- **Package `sos_render_pkg`:**
  - Constants CODE_EMPTY=3'b000, CODE_S=3'b001, CODE_O=3'b010, CODE_INVALID=3'b111.
  - Colour constants COL_BG, COL_S, COL_O, COL_HILITE.
  - GLYPH_W=8.
  - The S and O glyph row arrays.
  - A state enum.
- **Sub-module `sos_glyph_rom`:** combinational; takes (code, yc, xc) and returns the pixel bit.

## Test plan
- **Reset release, all cells 000:** 9×64 plots with colour 0, and `done` at cycle 585 after busy rises. First pixel (40,20); last pixel (103,83).
- **Set cell 4 to 001 after idle:** exactly 64 plots covering x 68–75, y 48–55. The pixel at (70,48) is 3'b100; the pixel at (68,48) is 0. No other cell is drawn.
- **Set cell 8 to 010 while cell 0 is drawing:** cell 8 is drawn at the end of the same pass. The pixel at (97,77) is 3'b001. `done` is asserted once.
- **redraw pulse during a pass:** the current pass finishes. After 1 IDLE cycle a second pass of 585 cycles starts and repaints all 9 cells.
- **Resetn low at DRAW pixel 30:** `vga_plot`=0 the next cycle. After release, a full 585-cycle pass follows.
- **With SOS_RENDER_HIGHLIGHT_EN, cells 0/4/8 = 001/010/001, then win_mask=9'h111:** only cells 0, 4 and 8 are redrawn, with foreground 3'b010.
